// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: host byte FIFO that hands bytes one at a time to the UART TX controller.
// Define UART_TX_FEEDER_IFG_EN to insert a GAP state of IFG_CYCLES idle cycles between frames.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int BUSY_WAIT  = 4,
  parameter int IFG_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   WR_EN,
  input  logic                   TX_BUSY,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   Data_Valid,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW,
  output logic                   LOST
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

`ifdef UART_TX_FEEDER_IFG_EN
  localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic [WW-1:0]         wait_cnt;
  state_t                state;
  state_t                state_nxt;
  logic                  push;
  logic                  pop;
  logic                  lost_hit;

  assign FULL  = (count == LW'(DEPTH));
  assign EMPTY = (count == '0);
  assign LEVEL = count;
  assign push  = WR_EN && !FULL;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    lost_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
          // The byte is abandoned rather than re-queued.
          lost_hit  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
`ifdef UART_TX_FEEDER_IFG_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef UART_TX_FEEDER_IFG_EN
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wait_cnt   <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      OVERFLOW   <= 1'b0;
      LOST       <= 1'b0;
    end else begin
      state      <= state_nxt;
      Data_Valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        P_DATA <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 1'b1 : '0;
      if (WR_EN && FULL) OVERFLOW <= 1'b1;
      if (lost_hit) LOST <= 1'b1;
    end
  end

`ifdef UART_TX_FEEDER_IFG_EN
  // Down-counter reloaded on GAP entry; GAP lasts IFG_CYCLES cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gap_cnt <= '0;
    end else if (state == WAIT_DONE && state_nxt == GAP) begin
      gap_cnt <= GW'(IFG_CYCLES);
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: self-checking bench with a TX controller model and a queue-based reference.
// Expected issue order and timing come from FIFO order and frame-level cycle arithmetic.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int BUSY_WAIT = 4;
  localparam int IFG       = 2;
  localparam int LW        = $clog2(DEPTH) + 1;
`ifdef UART_TX_FEEDER_IFG_EN
  localparam int GAP_EXP = IFG + 2;
`else
  localparam int GAP_EXP = 2;
`endif

  logic          CLK     = 1'b0;
  logic          RST     = 1'b0;
  logic          WR_EN   = 1'b0;
  logic          TX_BUSY = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, FULL, EMPTY, OVERFLOW, LOST;
  logic [LW-1:0] LEVEL;

  int checks = 0, failures = 0;
  int cycle = 0, last_act = 0, busy_left = 0, busy_len = 10;
  bit raise_pending = 0, hold_busy = 0, tx_respond = 1;
  logic [DW-1:0] dv_log[$];
  logic [DW-1:0] model_q[$];
  int dv_cyc[$];
  int fall_q[$];

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT), .IFG_CYCLES(IFG)) dut (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .TX_BUSY(TX_BUSY),
    .P_DATA(P_DATA), .Data_Valid(Data_Valid), .FULL(FULL), .EMPTY(EMPTY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .LOST(LOST)
  );

  always #5 CLK = ~CLK;

  // TX controller model plus issue logger; runs 1ns after each edge, tests act at 2ns.
  always begin : tx_model
    logic nb;
    @(posedge CLK); #1;
    cycle++;
    if (busy_left > 0) busy_left--;
    if (raise_pending) begin
      raise_pending = 0;
      busy_left     = busy_len;
    end
    if (Data_Valid === 1'b1) begin
      dv_log.push_back(P_DATA);
      dv_cyc.push_back(cycle);
      last_act = cycle;
      if (tx_respond) raise_pending = 1;
    end
    nb = hold_busy || (busy_left > 0);
    if (TX_BUSY && !nb) begin
      fall_q.push_back(cycle);
      last_act = cycle;
    end
    TX_BUSY = nb;
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic set_hold(input bit h);
    logic nb;
    hold_busy = h;
    nb = h || (busy_left > 0);
    if (TX_BUSY && !nb) begin
      fall_q.push_back(cycle);
      last_act = cycle;
    end
    TX_BUSY = nb;
  endtask

  task automatic do_reset();
    WR_EN = 0; hold_busy = 0; busy_left = 0; raise_pending = 0; tx_respond = 1; TX_BUSY = 0;
    RST = 1; tick(); tick(); RST = 0;
    dv_log.delete(); dv_cyc.delete(); fall_q.delete(); model_q.delete();
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (!(EMPTY === 1'b1 && !TX_BUSY && !raise_pending && busy_left == 0 && cycle - last_act >= 8)
           && n < 400) begin
      tick(); n++;
    end
    ok = (n < 400);
  endtask

  function automatic int fall_before(input int c);
    int f = -1000;
    foreach (fall_q[i]) if (fall_q[i] < c && fall_q[i] > f) f = fall_q[i];
    return f;
  endfunction

  task automatic test_reset();
    WR_EN = 1; WR_DATA = 8'hA5; RST = 1;
    tick(); tick();
    checks++;
    if ({Data_Valid, FULL, EMPTY, OVERFLOW, LOST} !== 5'b00100) begin
      failures++; $display("[TB] FAIL reset_flags: got %b expected 00100", {Data_Valid, FULL, EMPTY, OVERFLOW, LOST});
    end
    checks++;
    if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_pdata: got %h expected 00", P_DATA); end
    checks++;
    if (LEVEL !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", LEVEL); end
    RST = 0; WR_EN = 0;
    tick();
    checks++;
    if (LEVEL !== '0 || EMPTY !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_nothing_queued: level %0d empty %b expected 0/1", LEVEL, EMPTY);
    end
    repeat (4) tick();
    checks++;
    if (dv_log.size() != 0) begin failures++; $display("[TB] FAIL reset_no_issue: got %0d pulses expected 0", dv_log.size()); end
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset(); busy_len = 10;
    WR_EN = 1; WR_DATA = 8'h3C; tick(); WR_EN = 0;
    checks++;
    if (LEVEL !== LW'(1) || Data_Valid !== 1'b0) begin
      failures++; $display("[TB] FAIL single_after_write: level %0d dv %b expected 1/0", LEVEL, Data_Valid);
    end
    tick();
    checks++;
    if (Data_Valid !== 1'b1 || P_DATA !== 8'h3C) begin
      failures++; $display("[TB] FAIL single_issue: dv %b pdata %h expected 1/3c", Data_Valid, P_DATA);
    end
    checks++;
    if (LEVEL !== '0) begin failures++; $display("[TB] FAIL single_level: got %0d expected 0", LEVEL); end
    tick();
    checks++;
    if (Data_Valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_width: dv %b expected 0", Data_Valid); end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL single_drain: timed out expected idle"); end
    checks++;
    if (dv_log.size() != 1 || P_DATA !== 8'h3C) begin
      failures++; $display("[TB] FAIL single_one_pulse: %0d pulses pdata %h expected 1/3c", dv_log.size(), P_DATA);
    end
  endtask

  task automatic test_burst();
    bit ok;
    do_reset(); busy_len = 6;
    set_hold(1); tick();
    for (int i = 0; i < DEPTH; i++) begin
      WR_EN = 1; WR_DATA = DW'(i + 1); model_q.push_back(DW'(i + 1)); tick();
    end
    checks++;
    if (FULL !== 1'b1 || LEVEL !== LW'(DEPTH)) begin
      failures++; $display("[TB] FAIL burst_full: full %b level %0d expected 1/%0d", FULL, LEVEL, DEPTH);
    end
    WR_DATA = 8'hFF; tick(); WR_EN = 0;
    checks++;
    if (OVERFLOW !== 1'b1 || LEVEL !== LW'(DEPTH)) begin
      failures++; $display("[TB] FAIL burst_overflow: ovf %b level %0d expected 1/%0d", OVERFLOW, LEVEL, DEPTH);
    end
    set_hold(0);
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL burst_drain: timed out expected idle"); end
    checks++;
    if (dv_log.size() != model_q.size()) begin
      failures++; $display("[TB] FAIL burst_count: got %0d expected %0d", dv_log.size(), model_q.size());
    end else begin
      foreach (model_q[i]) begin
        checks++;
        if (dv_log[i] !== model_q[i]) begin
          failures++; $display("[TB] FAIL burst_order[%0d]: got %h expected %h", i, dv_log[i], model_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (dv_cyc[i] - fall_before(dv_cyc[i]) != GAP_EXP) begin
            failures++;
            $display("[TB] FAIL burst_gap[%0d]: got %0d expected %0d", i, dv_cyc[i] - fall_before(dv_cyc[i]), GAP_EXP);
          end
        end
      end
    end
    checks++;
    if (OVERFLOW !== 1'b1) begin failures++; $display("[TB] FAIL burst_overflow_sticky: got %b expected 1", OVERFLOW); end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    do_reset(); busy_len = $urandom_range(2, 6);
    set_hold(1); tick();
    repeat (DEPTH) begin
      WR_EN = 1; WR_DATA = DW'($urandom); model_q.push_back(WR_DATA); tick();
    end
    checks++;
    if (FULL !== 1'b1) begin failures++; $display("[TB] FAIL pp_full: got %b expected 1", FULL); end
    WR_DATA = DW'($urandom);
    set_hold(0); tick(); WR_EN = 0;
    checks++;
    if (LEVEL !== LW'(DEPTH - 1) || OVERFLOW !== 1'b1) begin
      failures++; $display("[TB] FAIL pp_level_ovf: level %0d ovf %b expected %0d/1", LEVEL, OVERFLOW, DEPTH - 1);
    end
    checks++;
    if (Data_Valid !== 1'b1 || P_DATA !== model_q[0]) begin
      failures++; $display("[TB] FAIL pp_issue: dv %b pdata %h expected 1/%h", Data_Valid, P_DATA, model_q[0]);
    end
    drain(ok);
    checks++;
    if (!ok || dv_log.size() != model_q.size()) begin
      failures++; $display("[TB] FAIL pp_count: got %0d expected %0d", dv_log.size(), model_q.size());
    end else begin
      foreach (model_q[i]) begin
        checks++;
        if (dv_log[i] !== model_q[i]) begin
          failures++; $display("[TB] FAIL pp_order[%0d]: got %h expected %h", i, dv_log[i], model_q[i]);
        end
      end
    end
  endtask

  task automatic test_lost();
    bit ok;
    logic [DW-1:0] b2;
    do_reset(); busy_len = 5;
    b2 = DW'($urandom);
    tx_respond = 0;
    WR_EN = 1; WR_DATA = 8'h55; tick();
    WR_DATA = b2; tick(); WR_EN = 0;
    checks++;
    if (Data_Valid !== 1'b1 || P_DATA !== 8'h55) begin
      failures++; $display("[TB] FAIL lost_first_issue: dv %b pdata %h expected 1/55", Data_Valid, P_DATA);
    end
    tx_respond = 1;
    repeat (BUSY_WAIT) tick();
    checks++;
    if (LOST !== 1'b0) begin failures++; $display("[TB] FAIL lost_early: got %b expected 0", LOST); end
    tick();
    checks++;
    if (LOST !== 1'b1 || Data_Valid !== 1'b0) begin
      failures++; $display("[TB] FAIL lost_set: lost %b dv %b expected 1/0", LOST, Data_Valid);
    end
    tick();
    checks++;
    if (Data_Valid !== 1'b1 || P_DATA !== b2) begin
      failures++; $display("[TB] FAIL lost_next_issue: dv %b pdata %h expected 1/%h", Data_Valid, P_DATA, b2);
    end
    drain(ok);
    checks++;
    if (!ok || dv_log.size() != 2 || LOST !== 1'b1) begin
      failures++; $display("[TB] FAIL lost_after: pulses %0d lost %b expected 2/1", dv_log.size(), LOST);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int wr_cyc[$];
    int exp_dv;
    do_reset(); busy_len = $urandom_range(2, 12);
    for (int i = 0; i < 6; i++) begin
      WR_EN = 1; WR_DATA = DW'($urandom); model_q.push_back(WR_DATA); tick(); WR_EN = 0;
      wr_cyc.push_back(cycle);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain(ok);
    checks++;
    if (!ok || dv_log.size() != model_q.size()) begin
      failures++; $display("[TB] FAIL b2b_count: got %0d expected %0d", dv_log.size(), model_q.size());
    end else begin
      exp_dv = 0;
      foreach (model_q[i]) begin
        // Issue follows either the write (empty idle FIFO) or the previous frame's end plus the gap.
        if (i == 0) exp_dv = wr_cyc[0] + 1;
        else exp_dv = (exp_dv + busy_len + 1 + GAP_EXP > wr_cyc[i] + 1) ?
                      exp_dv + busy_len + 1 + GAP_EXP : wr_cyc[i] + 1;
        checks++;
        if (dv_log[i] !== model_q[i] || dv_cyc[i] != exp_dv) begin
          failures++;
          $display("[TB] FAIL b2b_issue[%0d]: data %h at %0d expected %h at %0d", i, dv_log[i], dv_cyc[i], model_q[i], exp_dv);
        end
      end
    end
    checks++;
    if (OVERFLOW !== 1'b0 || LOST !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_flags: ovf %b lost %b expected 0/0", OVERFLOW, LOST);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    do_reset(); busy_len = 10;
    repeat (3) begin
      WR_EN = 1; WR_DATA = DW'($urandom_range(1, 255)); tick(); WR_EN = 0;
    end
    while (!TX_BUSY && n < 20) begin tick(); n++; end
    checks++;
    if (TX_BUSY !== 1'b1) begin failures++; $display("[TB] FAIL mid_frame_start: busy %b expected 1", TX_BUSY); end
    tick();
    RST = 1; tick(); RST = 0;
    checks++;
    if (LEVEL !== '0 || EMPTY !== 1'b1 || P_DATA !== 8'h00 || Data_Valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: level %0d empty %b pdata %h dv %b expected 0/1/00/0", LEVEL, EMPTY, P_DATA, Data_Valid);
    end
    dv_log.delete();
    repeat (30) tick();
    checks++;
    if (dv_log.size() != 0 || LEVEL !== '0) begin
      failures++; $display("[TB] FAIL mid_discard: pulses %0d level %0d expected 0/0", dv_log.size(), LEVEL);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_push_pop_full();
    test_lost();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmitter.
- Buffers bytes written by the host in a small synchronous FIFO.
- Issues them one at a time to the TX controller: a single-cycle Data_Valid pulse with P_DATA, then waits for the frame to finish using the TX busy flag.
- Keeps the host decoupled from frame timing; flags overflow and lost handshakes.

Parameters:
- DATA_WIDTH, 8: byte width, matching the serializer.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- BUSY_WAIT, 4: cycles allowed in WAIT_BUSY before the handshake is declared lost.
- IFG_CYCLES, 2: inter-frame idle cycles; used only with UART_TX_FEEDER_IFG_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_DATA  in  DATA_WIDTH  byte to enqueue.
- WR_EN  in  1  enqueue request.
- TX_BUSY  in  1  busy flag from the TX controller.
- P_DATA  out  DATA_WIDTH  byte presented to the serializer (registered).
- Data_Valid  out  1  one-cycle issue pulse (registered).
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky: a write was attempted while FULL.
- LOST  out  1  sticky: TX_BUSY never rose after an issue.

Behaviour:
- Reset: the single clock and a synchronous, active-high reset are fixed. RST sampled high at a CLK edge gives:
  - pointers = 0, count = 0, state = IDLE;
  - P_DATA = 0, Data_Valid = 0, FULL = 0, EMPTY = 1, LEVEL = 0, OVERFLOW = 0, LOST = 0.
  - Reset mid-frame discards all queued data and ends any handshake without waiting for TX_BUSY.
- Write side:
  - Write is accepted when WR_EN=1 and registered FULL=0.
  - A write while FULL is dropped and sets OVERFLOW, even if a pop happens in the same cycle.
  - Write pointer wraps modulo DEPTH.
- Pop: occurs only on the IDLE->ISSUE transition. Simultaneous accepted write and pop leaves count unchanged.
- FULL, EMPTY and LEVEL are derived from the registered count; they update the cycle after the edge that changes it.
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE (plus GAP with the optional feature):
  - IDLE: if EMPTY=0 and TX_BUSY=0, load P_DATA with the head entry, pop, set Data_Valid=1, go to ISSUE.
  - ISSUE: Data_Valid is high for exactly this one cycle; next state is WAIT_BUSY.
  - WAIT_BUSY: if TX_BUSY=1, go to WAIT_DONE. Otherwise count cycles; after BUSY_WAIT cycles set LOST and return to IDLE. The byte is not re-queued.
  - WAIT_DONE: stay while TX_BUSY=1; when TX_BUSY=0, go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE is accepted at edge k; Data_Valid is high during the cycle after edge k+1.
- P_DATA holds its value until the next issue.
- Back-to-back frames: at least one IDLE cycle always separates busy falling from the next Data_Valid.
- OVERFLOW and LOST clear only on RST.

Optional Feature:
- Macro UART_TX_FEEDER_IFG_EN.
- When defined: WAIT_DONE exits on TX_BUSY=0 to state GAP, which holds for IFG_CYCLES cycles (idle line, Data_Valid=0) before IDLE. A down-counter, reloaded on GAP entry, implements the hold.
- When undefined: no GAP state or counter is built; WAIT_DONE goes directly to IDLE. IFG_CYCLES is ignored.

Test Plan:
- Reset/idle: assert RST for 2 cycles with WR_EN=1, WR_DATA=0xA5 -> all outputs at reset values, LEVEL=0, nothing enqueued.
- Single byte: write 0x3C at edge k, TX model raises TX_BUSY the cycle after Data_Valid for 10 cycles -> Data_Valid high exactly one cycle after edge k+1, P_DATA=0x3C, LEVEL returns to 0, no second pulse.
- Burst/ordering: write 0x01..0x08 on consecutive cycles with DEPTH=8 -> FULL=1 after the 8th write; a 9th write (0xFF) sets OVERFLOW and is dropped; issued order is 0x01..0x08 with each Data_Valid only after TX_BUSY fell.
- Simultaneous push/pop at full: FIFO full and IDLE issuing while WR_EN=1 -> write dropped, OVERFLOW=1, LEVEL goes 8->7.
- Lost handshake: TX model never raises TX_BUSY after Data_Valid for 0x55 -> LOST=1 after 4 cycles in WAIT_BUSY, FSM back in IDLE, next byte issued normally.
- IFG (macro defined, IFG_CYCLES=2): two queued bytes -> exactly 2 GAP cycles plus 1 IDLE cycle between TX_BUSY falling and the second Data_Valid. Without the macro, exactly 1 IDLE cycle.
